// File: rtl/fft_7_pkg.sv
// Shared constants and types for the fft_7 twiddle multiplier path.
//   DATA_W     : sample / product width
//   COEF_W     : twiddle width (signed Q1.7)
//   CHAIN_LAT  : latency of the unsigned shift-add multiplier chain
//   PRE_SHIFT  : rounding right-shift applied to |sample| before the chain
//   SAT_POS/NEG: signed 16-bit extremes used by the back end
//   tag_t      : {valid, sign} token carried alongside the chain
package fft_7_pkg;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 8;
    localparam int CHAIN_LAT = 8;
    localparam int PRE_SHIFT = 7;

    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

    typedef struct packed {
        logic valid;
        logic sign;
    } tag_t;

endpackage

// File: rtl/mult_sign_dly_7.sv
// {valid, sign} delay line that runs in parallel with the multiplier chain
// so the sign and valid of each sample arrive together with its product.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (flushes the line)
//   tag_in    : token entering at the front-end register
//   tag_out   : token delayed by DEPTH cycles
module mult_sign_dly_7
    import fft_7_pkg::*;
#(
    parameter int DEPTH = CHAIN_LAT
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_reg [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/mult_sign_ctrl_7.sv
// Signed wrapper around the unsigned shift-add multiplier chain.
// Front end: |sample| is rounded down by PRE_SHIFT bits, |coef| is taken,
// both are registered into chain stage 0 and the product sign is launched
// into a delay line matching the chain latency.
// Back end: the chain product gets its sign back, positive overflow
// (only 256*128 = 32768) saturates to 32767.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   in_valid/in_sample/in_coef : signed input, one per cycle, no backpressure
//   chain_mult_1/_2/_pre/_en: operands and enable into chain stage 0
//   chain_prod/chain_rdy    : product and valid from the last chain stage
//   out_valid/out_data/out_sat : signed result, saturation flag
//   err_sticky/err_clr      : chain_rdy vs internal valid mismatch flag, clear
module mult_sign_ctrl_7
    import fft_7_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_sample,
    input  logic [COEF_W-1:0] in_coef,
    output logic [DATA_W-1:0] chain_mult_1,
    output logic [COEF_W-1:0] chain_mult_2,
    output logic [DATA_W-1:0] chain_pre,
    output logic              chain_en,
    input  logic [DATA_W-1:0] chain_prod,
    input  logic              chain_rdy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic              err_sticky,
    input  logic              err_clr
);

    // ---------------- front end ----------------
    // 17-bit magnitude so that |-32768| = 32768 is representable.
    logic [DATA_W:0]   s_ext;
    logic [DATA_W:0]   s_abs;
    logic [DATA_W:0]   s_round;
    logic [DATA_W-1:0] mag_s;
    logic [COEF_W:0]   c_ext;
    logic [COEF_W:0]   c_abs;
    logic [COEF_W-1:0] mag_c;
    logic              prod_sign;

    always_comb begin
        s_ext   = {in_sample[DATA_W-1], in_sample};
        s_abs   = in_sample[DATA_W-1] ? (~s_ext + 1'b1) : s_ext;
        s_round = s_abs + (17'd1 << (PRE_SHIFT - 1));
        // Result is at most 256, so the top bit is always dropped safely.
        mag_s   = DATA_W'(s_round >> PRE_SHIFT);
        c_ext   = {in_coef[COEF_W-1], in_coef};
        c_abs   = in_coef[COEF_W-1] ? (~c_ext + 1'b1) : c_ext;
        mag_c   = COEF_W'(c_abs);   // at most 128, fits unsigned 8 bits
        // A zero product must never come out as a negated zero.
        prod_sign = (in_sample[DATA_W-1] ^ in_coef[COEF_W-1])
                    && (mag_s != '0) && (mag_c != '0);
    end

    logic [DATA_W-1:0] mult_1_reg;
    logic [COEF_W-1:0] mult_2_reg;
    logic              en_reg;
    tag_t              tag_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_1_reg <= '0;
            mult_2_reg <= '0;
            en_reg     <= 1'b0;
            tag_reg    <= '0;
        end else if (in_valid) begin
            mult_1_reg <= mag_s;
            mult_2_reg <= mag_c;
            en_reg     <= 1'b1;
            tag_reg    <= '{valid: 1'b1, sign: prod_sign};
        end else begin
            mult_1_reg <= '0;
            mult_2_reg <= '0;
            en_reg     <= 1'b0;
            tag_reg    <= '0;
        end
    end

    assign chain_mult_1 = mult_1_reg;
    assign chain_mult_2 = mult_2_reg;
    assign chain_pre    = '0;
    assign chain_en     = en_reg;

    // ---------------- sign delay line ----------------
    tag_t tag_dly;

    mult_sign_dly_7 #(
        .DEPTH (CHAIN_LAT)
    ) u_dly (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_reg),
        .tag_out (tag_dly)
    );

    // ---------------- back end ----------------
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_sat_reg;
    logic              err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else if (tag_dly.valid) begin
            out_valid_reg <= 1'b1;
            if (tag_dly.sign) begin
                // -32768 is exactly representable, so negation never saturates.
                out_data_reg <= (chain_prod == SAT_NEG) ? SAT_NEG : (~chain_prod + 1'b1);
                out_sat_reg  <= 1'b0;
            end else if (chain_prod > SAT_POS) begin
                out_data_reg <= SAT_POS;
                out_sat_reg  <= 1'b1;
            end else begin
                out_data_reg <= chain_prod;
                out_sat_reg  <= 1'b0;
            end
        end else begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end
    end

    // The internal delay line is trusted for output qualification; chain_rdy
    // is only used as a health check. A new mismatch beats a clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (chain_rdy != tag_dly.valid) begin
            err_reg <= 1'b1;
        end else if (err_clr) begin
            err_reg <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_sat    = out_sat_reg;
    assign err_sticky = err_reg;

endmodule

// File: tb/tb_mult_sign_ctrl_7.sv
// Bench for mult_sign_ctrl_7 with a behavioural 8-stage multiplier chain
// connected between the chain_* ports.
module tb_mult_sign_ctrl_7;
    import fft_7_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_sample;
    logic [7:0]  in_coef;
    logic [15:0] chain_mult_1;
    logic [7:0]  chain_mult_2;
    logic [15:0] chain_pre;
    logic        chain_en;
    logic [15:0] chain_prod;
    logic        chain_rdy;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sat;
    logic        err_sticky;
    logic        err_clr;
    logic        force_rdy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_sign_ctrl_7 dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sample    (in_sample),
        .in_coef      (in_coef),
        .chain_mult_1 (chain_mult_1),
        .chain_mult_2 (chain_mult_2),
        .chain_pre    (chain_pre),
        .chain_en     (chain_en),
        .chain_prod   (chain_prod),
        .chain_rdy    (chain_rdy),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_sat      (out_sat),
        .err_sticky   (err_sticky),
        .err_clr      (err_clr)
    );

    // Behavioural stand-in for the 8-stage unsigned chain.
    logic [15:0] ch_prod [8];
    logic        ch_vld  [8];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                ch_prod[i] <= '0;
                ch_vld[i]  <= 1'b0;
            end
        end else begin
            ch_vld[0]  <= chain_en;
            ch_prod[0] <= 16'(32'(chain_mult_1) * 32'(chain_mult_2) + 32'(chain_pre));
            for (int i = 1; i < 8; i++) begin
                ch_vld[i]  <= ch_vld[i-1];
                ch_prod[i] <= ch_prod[i-1];
            end
        end
    end

    assign chain_prod = ch_prod[7];
    assign chain_rdy  = ch_vld[7] | force_rdy;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_model(input logic [15:0] s, input logic [7:0] c,
                                      output logic [15:0] d, output logic sat);
        int si, ci, as, ac, ms, p;
        bit neg;
        si = int'($signed(s));
        ci = int'($signed(c));
        as = (si < 0) ? -si : si;
        ac = (ci < 0) ? -ci : ci;
        ms = (as + 64) / 128;
        p  = ms * ac;
        neg = ((si < 0) != (ci < 0)) && (p != 0);
        if (neg) begin
            d = 16'(-p);
            sat = 1'b0;
        end else if (p > 32767) begin
            d = 16'h7FFF;
            sat = 1'b1;
        end else begin
            d = 16'(p);
            sat = 1'b0;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_sample = '0;
        in_coef = '0;
        err_clr = 1'b0;
        force_rdy = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, out_data, out_sat, err_sticky} !== 19'd0) begin
            errors++;
            $display("FAIL reset_out got v=%b d=%h s=%b e=%b exp all 0", out_valid, out_data, out_sat, err_sticky);
        end
        checks++;
        if ({chain_en, chain_mult_1, chain_mult_2, chain_pre} !== 41'd0) begin
            errors++;
            $display("FAIL reset_chain got en=%b m1=%h m2=%h pre=%h exp all 0", chain_en, chain_mult_1, chain_mult_2, chain_pre);
        end
        rst = 1'b0;
        tick();
        $display("reset: outputs idle");
    endtask

    task automatic test_directed();
        logic [15:0] vs  [4] = '{16'd1000, 16'h8000, 16'h8000, 16'd63};
        logic [7:0]  vc  [4] = '{8'd64, 8'h80, 8'd127, 8'hFB};
        logic [15:0] ms  [4] = '{16'd8, 16'd256, 16'd256, 16'd0};
        logic [7:0]  mc  [4] = '{8'd64, 8'd128, 8'd127, 8'd5};
        logic [15:0] ed  [4] = '{16'd512, 16'h7FFF, 16'h8100, 16'h0000};
        logic        es  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1;
            in_sample = vs[v];
            in_coef = vc[v];
            tick();
            in_valid = 1'b0;
            in_sample = '0;
            in_coef = '0;
            checks++;
            if (chain_en !== 1'b1 || chain_mult_1 !== ms[v] || chain_mult_2 !== mc[v]) begin
                errors++;
                $display("FAIL dir%0d_front got en=%b m1=%0d m2=%0d exp en=1 m1=%0d m2=%0d",
                         v, chain_en, chain_mult_1, chain_mult_2, ms[v], mc[v]);
            end
            for (int c = 2; c <= 11; c++) begin
                tick();
                if (c == 10) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== ed[v] || out_sat !== es[v]) begin
                        errors++;
                        $display("FAIL dir%0d_out got v=%b d=%h s=%b exp v=1 d=%h s=%b",
                                 v, out_valid, out_data, out_sat, ed[v], es[v]);
                    end
                end else begin
                    checks++;
                    if (out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL dir%0d_latency cycle %0d got out_valid=%b exp 0", v, c, out_valid);
                    end
                end
            end
            $display("directed %0d: sample=%h coef=%h -> data=%h sat=%b", v, vs[v], vc[v], ed[v], es[v]);
        end
    endtask

    task automatic test_random();
        logic        vin [200];
        logic [15:0] edat [200];
        logic        esat [200];
        logic [15:0] s;
        logic [7:0]  c;
        for (int i = 0; i < 210; i++) begin
            if (i >= 10) begin
                checks++;
                if (out_valid !== vin[i-10]) begin
                    errors++;
                    $display("FAIL rand%0d_valid got %b exp %b", i - 10, out_valid, vin[i-10]);
                end else if (vin[i-10]) begin
                    checks++;
                    if (out_data !== edat[i-10] || out_sat !== esat[i-10]) begin
                        errors++;
                        $display("FAIL rand%0d_data got d=%h s=%b exp d=%h s=%b",
                                 i - 10, out_data, out_sat, edat[i-10], esat[i-10]);
                    end else begin
                        $display("random %0d: data=%h sat=%b", i - 10, out_data, out_sat);
                    end
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_prefill%0d got out_valid=%b exp 0", i, out_valid);
                end
            end
            if (i < 200) begin
                case ($urandom_range(0, 9))
                    0: s = 16'h8000;
                    1: s = 16'h7FFF;
                    default: s = 16'($urandom);
                endcase
                case ($urandom_range(0, 9))
                    0: c = 8'h80;
                    1: c = 8'h7F;
                    default: c = 8'($urandom);
                endcase
                vin[i] = ($urandom_range(0, 3) != 0);
                ref_model(s, c, edat[i], esat[i]);
                in_valid = vin[i];
                in_sample = s;
                in_coef = c;
            end else begin
                in_valid = 1'b0;
                in_sample = '0;
                in_coef = '0;
            end
            tick();
        end
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL rand_err got err_sticky=%b exp 0", err_sticky);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_sample = 16'(1000 * (i + 1));
            in_coef = 8'd100;
            tick();
        end
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || chain_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_hold got v=%b en=%b exp 0 0", out_valid, chain_en);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        in_sample = '0;
        in_coef = '0;
        for (int c = 0; c < 15; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || err_sticky !== 1'b0) begin
                errors++;
                $display("FAIL midrst_release cycle %0d got v=%b err=%b exp 0 0", c, out_valid, err_sticky);
            end
        end
        $display("reset mid-burst: in-flight data dropped");
    endtask

    task automatic test_err_sticky();
        in_valid = 1'b1;
        in_sample = 16'd1000;
        in_coef = 8'd64;
        tick();
        in_valid = 1'b0;
        in_sample = '0;
        in_coef = '0;
        for (int c = 2; c <= 10; c++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd512 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL err_pre got v=%b d=%h err=%b exp v=1 d=0200 err=0", out_valid, out_data, err_sticky);
        end
        force_rdy = 1'b1;   // chain_rdy stays high one cycle too long
        tick();
        force_rdy = 1'b0;
        checks++;
        if (err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %b exp 1", err_sticky);
        end
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (err_sticky !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_hold got err=%b v=%b exp 1 0", err_sticky, out_valid);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL err_clr got %b exp 0", err_sticky);
        end
        force_rdy = 1'b1;
        err_clr = 1'b1;
        tick();
        force_rdy = 1'b0;
        err_clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL err_set_wins got %b exp 1", err_sticky);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL err_clr2 got %b exp 0", err_sticky);
        end
        $display("err_sticky: set, held, cleared, set beats clear");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_burst();
        test_err_sticky();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
